// File: rtl/vliw_pipe_pkg.sv
// Shared constants and helpers for the VLIW inter-stage latch.
// Occupancy encoding and lane slicing of packed bundle payloads.
package vliw_pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic int laneLo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One bundle register: valid bit, lane mask and packed payload.
// Clear drops only the valid bit so payload and mask hold their values.
module pipe_entry
  import vliw_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   clear,
  input  logic [LANES-1:0]       kill,
  input  logic [LANES*WIDTH-1:0] loadData,
  input  logic [LANES-1:0]       loadMask,
  output logic                   valid,
  output logic [LANES-1:0]       mask,
  output logic [LANES*WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      mask  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      mask  <= loadMask & ~kill;
      for (int i = 0; i < LANES; i++) begin
        data[laneLo(i, WIDTH) +: WIDTH] <=
          loadData[laneLo(i, WIDTH) +: WIDTH];
      end
    end else begin
      mask <= mask & ~kill;
    end
  end

endmodule

// File: rtl/vliw_pipe_stage.sv
// VLIW inter-stage latch with valid/ready on both sides, optional skid,
// flush, per-lane squash, empty-bundle dropping and a stall counter.
module vliw_pipe_stage
  import vliw_pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LANES      = 2,
  parameter int SKID       = 1,
  parameter int DROP_EMPTY = 0,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_lane_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_lane_valid,
  input  logic                   flush,
  input  logic [LANES-1:0]       lane_kill,
  output logic [1:0]             occupancy,
  output logic [CNT_W-1:0]       stall_count,
  input  logic                   stat_clr
);

  logic                   mainValid;
  logic                   skidValid;
  logic [LANES-1:0]       mainMask;
  logic [LANES-1:0]       skidMask;
  logic [LANES*WIDTH-1:0] mainData;
  logic [LANES*WIDTH-1:0] skidData;
  logic [LANES*WIDTH-1:0] srcData;
  logic [LANES-1:0]       srcMask;
  logic inFire, outFire, dropIt, take;
  logic mainLoad, mainClear, skidLoad, skidClear;
  logic mainNext, skidNext;

  assign outFire = mainValid & out_ready;

  if (SKID != 0) begin : gRdySkid
    assign in_ready = !skidValid;
  end else begin : gRdyComb
    assign in_ready = !mainValid | out_ready;
  end

  assign inFire = in_valid & in_ready;
  assign dropIt = (DROP_EMPTY != 0) && (in_lane_valid == '0);
  assign take   = inFire & !dropIt;

  // A full stage refills main from skid; otherwise main takes the input
  assign mainLoad  = !flush &
    (skidValid ? outFire : (take & (!mainValid | outFire)));
  assign mainClear = flush | (outFire & !mainLoad);
  assign skidLoad  = !flush & take & mainValid & !outFire;
  assign skidClear = flush | (skidValid & outFire);

  assign srcData = skidValid ? skidData : in_data;
  assign srcMask = skidValid ? skidMask : in_lane_valid;

  assign mainNext = mainLoad | (mainValid & !mainClear);
  assign skidNext = skidLoad | (skidValid & !skidClear);

  pipe_entry #(.WIDTH(WIDTH), .LANES(LANES)) uMain (
    .clk      (clk),
    .rst_n    (reset),
    .load     (mainLoad),
    .clear    (mainClear),
    .kill     (lane_kill),
    .loadData (srcData),
    .loadMask (srcMask),
    .valid    (mainValid),
    .mask     (mainMask),
    .data     (mainData)
  );

  if (SKID != 0) begin : gSkid
    pipe_entry #(.WIDTH(WIDTH), .LANES(LANES)) uSkid (
      .clk      (clk),
      .rst_n    (reset),
      .load     (skidLoad),
      .clear    (skidClear),
      .kill     (lane_kill),
      .loadData (in_data),
      .loadMask (in_lane_valid),
      .valid    (skidValid),
      .mask     (skidMask),
      .data     (skidData)
    );
  end else begin : gNoSkid
    assign skidValid = 1'b0;
    assign skidMask  = '0;
    assign skidData  = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= OCC_EMPTY;
    end else begin
      case ({mainNext, skidNext})
        2'b00:   occupancy <= OCC_EMPTY;
        2'b11:   occupancy <= OCC_FULL;
        default: occupancy <= OCC_ONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stat_clr) begin
      stall_count <= '0;
    end else if (mainValid & !out_ready & !flush & ~&stall_count) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign out_valid      = mainValid;
  assign out_data       = mainData;
  assign out_lane_valid = mainMask;

endmodule

// File: tb/tb_vliw_pipe_stage.sv
// Bench for vliw_pipe_stage: vector table plus FIFO scoreboard on the
// default build, hand sequences on a SKID=0/DROP_EMPTY=1/CNT_W=4 build.
module tb_vliw_pipe_stage;
  import vliw_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        aInValid, aInReady, aOutValid, aOutReady, aFlush, aClr;
  logic [63:0] aInData, aOutData;
  logic [1:0]  aInLv, aOutLv, aKill, aOcc;
  logic [15:0] aStall;

  logic        bInValid, bInReady, bOutValid, bOutReady, bFlush, bClr;
  logic [63:0] bInData, bOutData;
  logic [1:0]  bInLv, bOutLv, bKill, bOcc;
  logic [3:0]  bStall;

  vliw_pipe_stage #(.WIDTH(32), .LANES(2), .SKID(1),
    .DROP_EMPTY(0), .CNT_W(16)) dutA (
    .clk(clk), .reset(reset),
    .in_valid(aInValid), .in_ready(aInReady),
    .in_data(aInData), .in_lane_valid(aInLv),
    .out_valid(aOutValid), .out_ready(aOutReady),
    .out_data(aOutData), .out_lane_valid(aOutLv),
    .flush(aFlush), .lane_kill(aKill),
    .occupancy(aOcc), .stall_count(aStall), .stat_clr(aClr)
  );

  vliw_pipe_stage #(.WIDTH(32), .LANES(2), .SKID(0),
    .DROP_EMPTY(1), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset),
    .in_valid(bInValid), .in_ready(bInReady),
    .in_data(bInData), .in_lane_valid(bInLv),
    .out_valid(bOutValid), .out_ready(bOutReady),
    .out_data(bOutData), .out_lane_valid(bOutLv),
    .flush(bFlush), .lane_kill(bKill),
    .occupancy(bOcc), .stall_count(bStall), .stat_clr(bClr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mask;
  } item_t;

  item_t sbq[$];

  // Reference FIFO: push on accepted input, pop on downstream transfer
  always @(negedge clk) begin : monA
    item_t e;
    if (!reset) begin
      sbq.delete();
    end else begin
      chk("A out_valid vs model", 64'(aOutValid), 64'(sbq.size() != 0));
      chk("A occupancy vs model", 64'(aOcc), 64'(sbq.size()));
      if (aOutValid && aOutReady) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL A pop: got data %h with empty model", aOutData);
        end else begin
          e = sbq.pop_front();
          chk("A pop data", aOutData, e.data);
          chk("A pop mask", 64'(aOutLv), 64'(e.mask));
        end
      end
      if (aFlush) begin
        sbq.delete();
      end else begin
        foreach (sbq[i]) sbq[i].mask = sbq[i].mask & ~aKill;
        if (aInValid && aInReady) begin
          e.data = aInData;
          e.mask = aInLv & ~aKill;
          sbq.push_back(e);
        end
      end
    end
  end

  typedef struct {
    logic        inValid;
    logic [63:0] data;
    logic [1:0]  lv;
    logic        outReady;
    logic [1:0]  kill;
    logic        flush;
    logic        clr;
    logic        expOv;
    logic [1:0]  expMask;
    logic [1:0]  expOcc;
    logic        expRdy;
    logic [15:0] expStall;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{1, 64'h0000000A_00000005, 2'b11, 1, 2'b00, 0, 0,
                 1, 2'b11, 2'd1, 1, 16'd0};
    vecs[1]  = '{0, 64'h0, 2'b00, 1, 2'b00, 0, 0,
                 0, 2'b00, 2'd0, 1, 16'd0};
    vecs[2]  = '{1, 64'h11111111_22222222, 2'b11, 0, 2'b00, 0, 0,
                 1, 2'b11, 2'd1, 1, 16'd0};
    vecs[3]  = '{1, 64'h33333333_44444444, 2'b01, 0, 2'b00, 0, 0,
                 1, 2'b11, 2'd2, 0, 16'd1};
    vecs[4]  = '{0, 64'h0, 2'b00, 0, 2'b00, 0, 0,
                 1, 2'b11, 2'd2, 0, 16'd2};
    vecs[5]  = '{0, 64'h0, 2'b00, 1, 2'b00, 0, 0,
                 1, 2'b01, 2'd1, 1, 16'd2};
    vecs[6]  = '{0, 64'h0, 2'b00, 1, 2'b00, 0, 0,
                 0, 2'b00, 2'd0, 1, 16'd2};
    vecs[7]  = '{1, 64'hC1C1C1C1_01010101, 2'b11, 0, 2'b00, 0, 0,
                 1, 2'b11, 2'd1, 1, 16'd2};
    vecs[8]  = '{1, 64'hC2C2C2C2_02020202, 2'b11, 0, 2'b00, 0, 0,
                 1, 2'b11, 2'd2, 0, 16'd3};
    vecs[9]  = '{1, 64'hC3C3C3C3_03030303, 2'b11, 0, 2'b00, 1, 0,
                 0, 2'b00, 2'd0, 1, 16'd3};
    vecs[10] = '{1, 64'hC4C4C4C4_04040404, 2'b11, 0, 2'b00, 0, 0,
                 1, 2'b11, 2'd1, 1, 16'd3};
    vecs[11] = '{1, 64'hC5C5C5C5_05050505, 2'b11, 1, 2'b00, 1, 0,
                 0, 2'b00, 2'd0, 1, 16'd3};
    vecs[12] = '{1, 64'hDDDD0000_0000DDDD, 2'b11, 0, 2'b00, 0, 0,
                 1, 2'b11, 2'd1, 1, 16'd3};
    vecs[13] = '{0, 64'h0, 2'b00, 0, 2'b10, 0, 0,
                 1, 2'b01, 2'd1, 1, 16'd4};
    vecs[14] = '{0, 64'h0, 2'b00, 1, 2'b00, 0, 0,
                 0, 2'b00, 2'd0, 1, 16'd4};
    vecs[15] = '{1, 64'hEEEE1111_2222EEEE, 2'b11, 0, 2'b01, 0, 0,
                 1, 2'b10, 2'd1, 1, 16'd4};
    vecs[16] = '{1, 64'hFFFF3333_4444FFFF, 2'b11, 0, 2'b10, 0, 0,
                 1, 2'b00, 2'd2, 0, 16'd5};
    vecs[17] = '{0, 64'h0, 2'b00, 1, 2'b00, 0, 0,
                 1, 2'b01, 2'd1, 1, 16'd5};
    vecs[18] = '{0, 64'h0, 2'b00, 1, 2'b00, 0, 1,
                 0, 2'b00, 2'd0, 1, 16'd0};

    aInValid = 0; aInData = '0; aInLv = '0; aOutReady = 0;
    aFlush = 0; aKill = '0; aClr = 0;
    bInValid = 0; bInData = '0; bInLv = '0; bOutReady = 0;
    bFlush = 0; bKill = '0; bClr = 0;

    #12;
    chk("A rst out_valid", 64'(aOutValid), 64'd0);
    chk("A rst out_data", aOutData, 64'd0);
    chk("A rst lane_valid", 64'(aOutLv), 64'd0);
    chk("A rst occupancy", 64'(aOcc), 64'd0);
    chk("A rst stall", 64'(aStall), 64'd0);
    chk("A rst in_ready", 64'(aInReady), 64'd1);
    chk("B rst out_valid", 64'(bOutValid), 64'd0);
    chk("B rst in_ready", 64'(bInReady), 64'd1);
    chk("B rst stall", 64'(bStall), 64'd0);

    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      aInValid  = vecs[i].inValid;
      aInData   = vecs[i].data;
      aInLv     = vecs[i].lv;
      aOutReady = vecs[i].outReady;
      aKill     = vecs[i].kill;
      aFlush    = vecs[i].flush;
      aClr      = vecs[i].clr;
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", i), 64'(aOutValid),
          64'(vecs[i].expOv));
      if (vecs[i].expOv)
        chk($sformatf("row%0d lane_valid", i), 64'(aOutLv),
            64'(vecs[i].expMask));
      chk($sformatf("row%0d occupancy", i), 64'(aOcc),
          64'(vecs[i].expOcc));
      chk($sformatf("row%0d in_ready", i), 64'(aInReady),
          64'(vecs[i].expRdy));
      chk($sformatf("row%0d stall", i), 64'(aStall),
          64'(vecs[i].expStall));
      if (i == 0)
        chk("row0 out_data", aOutData, 64'h0000000A_00000005);
    end
    aInValid = 0; aOutReady = 0; aKill = '0; aFlush = 0; aClr = 0;
    chk("A model drained", 64'(sbq.size()), 64'd0);

    // SKID=0 / DROP_EMPTY=1 build
    bInValid = 1; bInData = 64'hCAFE0001_BEEF0002; bInLv = 2'b11;
    bOutReady = 0;
    @(posedge clk); #1;
    bInValid = 0;
    chk("B load out_valid", 64'(bOutValid), 64'd1);
    chk("B load data", bOutData, 64'hCAFE0001_BEEF0002);
    chk("B lane1 slice", 64'(bOutData[laneLo(1, 32) +: 32]),
        64'h0000_0000_CAFE_0001);
    chk("B load occupancy", 64'(bOcc), 64'd1);
    #1 chk("B in_ready held", 64'(bInReady), 64'd0);
    bOutReady = 1;
    #1 chk("B in_ready comb up", 64'(bInReady), 64'd1);
    bOutReady = 0;
    #1 chk("B in_ready comb down", 64'(bInReady), 64'd0);

    bOutReady = 1; bInValid = 1; bInData = 64'h12345678_9ABCDEF0;
    bInLv = 2'b00;
    @(posedge clk); #1;
    chk("B drop out_valid", 64'(bOutValid), 64'd0);
    chk("B drop occupancy", 64'(bOcc), 64'd0);
    chk("B drop in_ready", 64'(bInReady), 64'd1);
    @(posedge clk); #1;
    chk("B drop empty stage", 64'(bOutValid), 64'd0);

    bInData = 64'h0000_0000_5A5A_5A5A; bInLv = 2'b01; bOutReady = 0;
    @(posedge clk); #1;
    bInValid = 0;
    chk("B stall start", 64'(bStall), 64'd0);
    chk("B held mask", 64'(bOutLv), 64'd1);
    repeat (5) @(posedge clk);
    #1 chk("B stall 5", 64'(bStall), 64'd5);
    repeat (15) @(posedge clk);
    #1 chk("B stall saturated", 64'(bStall), 64'd15);
    bClr = 1;
    @(posedge clk); #1;
    bClr = 0;
    chk("B stat_clr", 64'(bStall), 64'd0);
    chk("B data held", bOutData, 64'h0000_0000_5A5A_5A5A);
    bOutReady = 1;
    @(posedge clk); #1;
    chk("B final drain", 64'(bOutValid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vliw_pipe_stage.md
Name: vliw_pipe_stage

Overview:
Parametrised successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It holds one VLIW bundle per entry: LANES lanes of WIDTH-bit payload, each with a lane-valid bit. Transfer uses valid/ready handshakes on both sides, with an optional skid entry so that in_ready is registered. It adds behaviour the fixed latches lack:
- whole-stage flush
- per-lane squash
- empty-bundle dropping
- a saturating stall counter

One instance sits between each pair of pipeline stages.

Parameters:
- WIDTH, 32, payload bits per lane.
- LANES, 2, bundle issue width.
- SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- DROP_EMPTY, 0, 1 = an accepted bundle with all lane-valid bits zero is discarded, not stored.
- CNT_W, 16, width of stall counter.

Ports:
- clk, input, 1, clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream bundle present.
- in_ready, output, 1, stage can accept.
- in_data, input, LANES*WIDTH, lane i occupies bits [i*WIDTH +: WIDTH].
- in_lane_valid, input, LANES, per-lane valid.
- out_valid, output, 1, stored bundle present.
- out_ready, input, 1, downstream accepts.
- out_data, output, LANES*WIDTH, head-entry payload.
- out_lane_valid, output, LANES, head-entry lane mask.
- flush, input, 1, synchronous invalidate of all entries.
- lane_kill, input, LANES, synchronous clear of the selected lane-valid bits in all stored entries.
- occupancy, output, 2, entries held (0..2; max 1 when SKID=0).
- stall_count, output, CNT_W, cycles with out_valid=1 and out_ready=0.
- stat_clr, input, 1, synchronous clear of stall_count.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_data=0, out_lane_valid=0, occupancy=0, stall_count=0.
  - Skid entry invalid, its data 0.
  - in_ready=1.
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_valid must stay high with data stable until in_fire.
  - The stage holds out_valid and data stable until out_fire.
- Latency: an accepted bundle appears at the output the next cycle when the stage was empty. There is no combinational in-to-out path.
- SKID=1, registered in_ready = !skid_valid. States are EMPTY, ONE and FULL, with transitions:
  - EMPTY + in_fire → ONE; main loads input.
  - ONE + in_fire + out_fire → ONE; main loads input.
  - ONE + in_fire + !out_fire → FULL; skid loads input.
  - ONE + !in_fire + out_fire → EMPTY.
  - FULL + out_fire → ONE; main takes skid. No input is accepted since in_ready=0.
  - FULL + !out_fire → FULL.
- SKID=0: in_ready = !out_valid | out_ready, combinational. Main loads on in_fire.
- Ordering: strictly FIFO; a bundle never overtakes an older one.
- DROP_EMPTY=1: an in_fire with in_lane_valid all zero is consumed with no state change apart from out_fire effects.
- flush (priority over everything except reset):
  - Next state is EMPTY, and that cycle's in_fire bundle is discarded.
  - out_fire that cycle still counts as a transfer downstream.
  - Payload registers are held, not zeroed.
- lane_kill:
  - Clears matching out_lane_valid bits and the skid lane bits next cycle.
  - Entries stay valid even if all lanes are cleared.
  - Also masks an incoming bundle loaded in the same cycle.
  - Kill and load in the same cycle → stored mask = in_lane_valid & ~lane_kill.
- stall_count:
  - Increments each cycle with out_valid & !out_ready & !flush.
  - Saturates at all-ones.
  - stat_clr has priority → 0.
- occupancy: registered, equal to the number of valid entries.

Decomposition:
- Package vliw_pipe_pkg holds:
  - Occupancy encoding constants: OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
  - A lane-slice helper function for in_data/out_data indexing.
- Sub-module pipe_entry: one entry holding a valid bit, a LANES-bit lane mask and a LANES*WIDTH payload, with load/clear/kill controls.
  - Instantiated once for main.
  - Instantiated a second time for skid when SKID=1.

Test Plan:
1. Reset, then single bundle:
   - Hold reset=0 and check all outputs are zero and in_ready=1.
   - Release reset; drive in_data=0x0000000A_00000005, in_lane_valid=2'b11, out_ready=1.
   - Next cycle: out_valid=1, out_data matches, occupancy=1.
2. Backpressure (SKID=1):
   - Hold out_ready=0 and send bundles A and B.
   - Expect occupancy=2 and in_ready=0; stall_count increments each stalled cycle.
   - Raise out_ready: A then B on consecutive cycles, then occupancy=0.
3. Flush with same-cycle load while FULL:
   - Assert flush=1 with in_valid=1 and bundle C.
   - Next cycle: out_valid=0, occupancy=0, C never emerges, in_ready=1.
4. lane_kill:
   - While holding bundle with mask 2'b11, pulse lane_kill=2'b10.
   - Next cycle: out_lane_valid=2'b01, out_valid=1, payload unchanged.
   - Also load with lane_kill=2'b01 → stored mask 2'b10.
5. SKID=0 and DROP_EMPTY=1 build:
   - in_ready follows out_ready combinationally while full.
   - A bundle with in_lane_valid=2'b00 is accepted with out_valid staying 0.
6. Saturation (CNT_W=4): 20 stall cycles → stall_count=15; stat_clr=1 → 0 next cycle.
